// File: rtl/ysyx_25020037_lsu_pkg.sv
// Shared LSU configuration: write-back bus width, funct3 access-size encodings,
// AXI response codes, FSM state type and access-size helpers.
package ysyx_25020037_lsu_pkg;

  localparam int XLEN            = 32;
  localparam int LU_TO_WU_BUS_WD = 33;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_D  = 3'd2,
    S_WR_AW = 3'd3,
    S_WR_B  = 3'd4,
    S_DONE  = 3'd5
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // Encodings outside b/h/bu/hu fall through to a word access.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3_size(f3))
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25020037_lsu_align.sv
// Combinational data alignment: load byte/half extract with sign/zero extension,
// and store lane shifting with byte-strobe generation.
module ysyx_25020037_lsu_align
  import ysyx_25020037_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] sdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o
);

  logic [4:0]  sh;
  logic [31:0] rsh;
  logic        sext;

  always_comb begin
    sh        = {off_i, 3'b000};
    rsh       = rdata_i >> sh;
    sext      = ~funct3_i[2];
    ld_data_o = rdata_i;
    wdata_o   = sdata_i;
    wstrb_o   = 4'b1111;
    case (f3_size(funct3_i))
      SZ_B: begin
        ld_data_o = {{24{sext & rsh[7]}}, rsh[7:0]};
        wdata_o   = sdata_i << sh;
        wstrb_o   = 4'b0001 << off_i;
      end
      SZ_H: begin
        ld_data_o = {{16{sext & rsh[15]}}, rsh[15:0]};
        wdata_o   = sdata_i << sh;
        wstrb_o   = 4'b0011 << off_i;
      end
      default: begin
        ld_data_o = rdata_i;
        wdata_o   = sdata_i;
        wstrb_o   = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_25020037_lsu.sv
// Load/store unit: accepts one EXU beat, runs at most one AXI4-Lite read or write,
// and holds a single {fault, rd_data} write-back beat until the WBU takes it.
module ysyx_25020037_lsu
  import ysyx_25020037_lsu_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter bit RESP_FAULT_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       exu_valid,
  output logic                       lsu_ready,
  input  logic [63:0]                eu_to_lu_bus,
  input  logic                       inst_l,
  input  logic                       inst_s,
  input  logic [2:0]                 funct3,
  output logic                       lsu_valid,
  input  logic                       wbu_ready,
  output logic [LU_TO_WU_BUS_WD-1:0] lu_to_wu_bus,
  output logic [ADDR_W-1:0]          araddr,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [31:0]                rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rvalid,
  output logic                       rready,
  output logic [ADDR_W-1:0]          awaddr,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [31:0]                wdata,
  output logic [3:0]                 wstrb,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic [1:0]                 bresp,
  input  logic                       bvalid,
  output logic                       bready
);

  localparam logic FAULT_EN = RESP_FAULT_EN;

  lsu_state_e                 state_q, state_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [2:0]                 f3_q, f3_d;
  logic                       ready_q, ready_d;
  logic                       valid_q, valid_d;
  logic                       arvalid_q, arvalid_d;
  logic                       rready_q, rready_d;
  logic                       awvalid_q, awvalid_d;
  logic                       wvalid_q, wvalid_d;
  logic                       bready_q, bready_d;
  logic [31:0]                wdata_q, wdata_d;
  logic [3:0]                 wstrb_q, wstrb_d;
  logic [LU_TO_WU_BUS_WD-1:0] bus_q, bus_d;

  logic [31:0] in_addr, in_data, ld_data, st_data;
  logic [3:0]  st_strb;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic        aw_fin, w_fin;

  assign in_addr = eu_to_lu_bus[63:32];
  assign in_data = eu_to_lu_bus[31:0];

  // Stores are shaped from the incoming beat in IDLE; loads use the latched access.
  assign al_f3  = (state_q == S_IDLE) ? funct3 : f3_q;
  assign al_off = (state_q == S_IDLE) ? in_addr[1:0] : addr_q[1:0];

  ysyx_25020037_lsu_align u_align (
    .funct3_i  (al_f3),
    .off_i     (al_off),
    .rdata_i   (rdata),
    .sdata_i   (in_data),
    .ld_data_o (ld_data),
    .wdata_o   (st_data),
    .wstrb_o   (st_strb)
  );

  // A write channel counts as finished once its valid has dropped or handshakes now.
  assign aw_fin = ~awvalid_q | awready;
  assign w_fin  = ~wvalid_q | wready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    f3_d      = f3_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bus_d     = bus_q;
    case (state_q)
      S_IDLE: begin
        if (exu_valid && ready_q) begin
          addr_d  = in_addr;
          f3_d    = funct3;
          ready_d = 1'b0;
          if ((inst_l || inst_s) && misaligned(funct3, in_addr[1:0])) begin
            bus_d   = {1'b1, 32'h0000_0000};
            valid_d = 1'b1;
            state_d = S_DONE;
          end else if (inst_l) begin
            arvalid_d = 1'b1;
            state_d   = S_RD_A;
          end else if (inst_s) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wdata_d   = st_data;
            wstrb_d   = st_strb;
            state_d   = S_WR_AW;
          end else begin
            bus_d   = {1'b0, in_addr};
            valid_d = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_A: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_D;
        end else begin
          state_d = S_RD_A;
        end
      end
      S_RD_D: begin
        if (rvalid) begin
          rready_d = 1'b0;
          bus_d    = {FAULT_EN & (rresp != RESP_OKAY), ld_data};
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_RD_D;
        end
      end
      S_WR_AW: begin
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (aw_fin && w_fin) begin
          bready_d = 1'b1;
          state_d  = S_WR_B;
        end else begin
          state_d = S_WR_AW;
        end
      end
      S_WR_B: begin
        if (bvalid) begin
          bready_d = 1'b0;
          bus_d    = {FAULT_EN & (bresp != RESP_OKAY), 32'h0000_0000};
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_WR_B;
        end
      end
      S_DONE: begin
        if (wbu_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        ready_d   = 1'b1;
        valid_d   = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        bus_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      f3_q      <= 3'b000;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      wdata_q   <= 32'h0000_0000;
      wstrb_q   <= 4'b0000;
      bus_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      f3_q      <= f3_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bus_q     <= bus_d;
    end
  end

  assign lsu_ready    = ready_q;
  assign lsu_valid    = valid_q;
  assign lu_to_wu_bus = bus_q;
  assign araddr       = addr_q;
  assign arvalid      = arvalid_q;
  assign rready       = rready_q;
  assign awaddr       = addr_q;
  assign awvalid      = awvalid_q;
  assign wdata        = wdata_q;
  assign wstrb        = wstrb_q;
  assign wvalid       = wvalid_q;
  assign bready       = bready_q;

endmodule
